// File: rtl/sha1_chain_ctrl.sv
// SHA-1 chaining controller plus the combinational SHA-1 compression core it drives.
// The core is a pure function of (block, chaining value). The controller registers both
// inputs and gives the core COMB_LATENCY cycles, as a multicycle path, before capturing
// its result.

module sha1 (
    input  logic [511:0] blk_i,
    input  logic [159:0] chain_i,
    output logic [159:0] hash_o
);
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, e, f, k, wt, tmp;

    // Fully unrolled 80-round compression; the message schedule uses a rolling 16-word window
    always_comb begin
        for (int i = 0; i < 16; i++) w[i] = '0;
        a   = chain_i[159:128];
        b   = chain_i[127:96];
        c   = chain_i[95:64];
        d   = chain_i[63:32];
        e   = chain_i[31:0];
        f   = '0;
        k   = '0;
        wt  = '0;
        tmp = '0;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) begin
                wt = blk_i[511-32*t -: 32];
            end else begin
                wt = w[4'(t+13)] ^ w[4'(t+8)] ^ w[4'(t+2)] ^ w[4'(t)];
                wt = {wt[30:0], wt[31]};
            end
            w[4'(t)] = wt;
            if (t < 20) begin
                f = (b & c) | (~b & d);
                k = 32'h5A827999;
            end else if (t < 40) begin
                f = b ^ c ^ d;
                k = 32'h6ED9EBA1;
            end else if (t < 60) begin
                f = (b & c) | (d & (b | c));
                k = 32'h8F1BBCDC;
            end else begin
                f = b ^ c ^ d;
                k = 32'hCA62C1D6;
            end
            tmp = {a[26:0], a[31:27]} + f + e + k + wt;
            e   = d;
            d   = c;
            c   = {b[1:0], b[31:2]};
            b   = a;
            a   = tmp;
        end
        hash_o = {chain_i[159:128] + a, chain_i[127:96] + b, chain_i[95:64] + c,
                  chain_i[63:32] + d, chain_i[31:0] + e};
    end
endmodule

module sha1_chain_ctrl #(
    parameter int           COMB_LATENCY = 1,
    parameter logic [159:0] IV           = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0,
    parameter int           CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             blk_valid_i,
    output logic             blk_ready_o,
    input  logic [511:0]     blk_data_i,
    input  logic             blk_first_i,
    input  logic             blk_last_i,
    output logic             digest_valid_o,
    input  logic             digest_ready_i,
    output logic [159:0]     digest_o,
    output logic [CNT_W-1:0] msg_blocks_o,
    output logic             busy_o
);
    localparam int LAT_W = (COMB_LATENCY > 1) ? $clog2(COMB_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [159:0]       chain_q, chain_d;
    logic [511:0]       blk_q, blk_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [159:0]       digest_q, digest_d;
    logic [CNT_W-1:0]   mb_q, mb_d;
    logic               dv_q, dv_d;
    logic [159:0]       new_hash;

    sha1 u_core (
        .blk_i   (blk_q),
        .chain_i (chain_q),
        .hash_o  (new_hash)
    );

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            chain_q  <= IV;
            blk_q    <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            lat_q    <= '0;
            digest_q <= IV;
            mb_q     <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            chain_q  <= chain_d;
            blk_q    <= blk_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            digest_q <= digest_d;
            mb_q     <= mb_d;
            dv_q     <= dv_d;
        end
    end

    // Next-state: accept a block, wait out the core latency, then chain or publish
    always_comb begin
        state_d  = state_q;
        chain_d  = chain_q;
        blk_d    = blk_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        digest_d = digest_q;
        mb_d     = mb_q;
        dv_d     = dv_q;
        case (state_q)
            S_IDLE: begin
                if (blk_valid_i) begin
                    blk_d  = blk_data_i;
                    last_d = blk_last_i;
                    lat_d  = LAT_W'(COMB_LATENCY - 1);
                    if (blk_first_i) begin
                        // A new message discards whatever partial chain was in flight
                        chain_d = IV;
                        cnt_d   = CNT_W'(1);
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    chain_d = new_hash;
                    if (last_q) begin
                        digest_d = new_hash;
                        mb_d     = cnt_q;
                        dv_d     = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                // Reload IV so a following block without blk_first still starts clean
                if (digest_ready_i) begin
                    dv_d    = 1'b0;
                    chain_d = IV;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign blk_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign digest_valid_o = dv_q;
    assign digest_o       = digest_q;
    assign msg_blocks_o   = mb_q;
endmodule

// File: tb/tb_sha1_chain_ctrl.sv
// Bench for sha1_chain_ctrl: three instances (latency 1, latency 4, 2-bit counter)
// checked against known SHA-1 vectors and a message-level reference model.
module tb_sha1_chain_ctrl;
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam int LAT [3] = '{1, 4, 1};
    localparam int SAT [3] = '{65535, 65535, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         bv [3];
    logic         bf [3];
    logic         bl [3];
    logic         dr [3];
    logic [511:0] bd [3];
    logic         br [3];
    logic         dv [3];
    logic         bz [3];
    logic [159:0] dg [3];
    logic [15:0]  mb [3];
    logic [15:0]  mb0, mb1;
    logic [1:0]   mb2;
    assign mb[0] = mb0;
    assign mb[1] = mb1;
    assign mb[2] = {14'd0, mb2};

    sha1_chain_ctrl #(.COMB_LATENCY(1), .CNT_W(16)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .blk_valid_i(bv[0]), .blk_ready_o(br[0]),
        .blk_data_i(bd[0]), .blk_first_i(bf[0]), .blk_last_i(bl[0]),
        .digest_valid_o(dv[0]), .digest_ready_i(dr[0]), .digest_o(dg[0]),
        .msg_blocks_o(mb0), .busy_o(bz[0]));
    sha1_chain_ctrl #(.COMB_LATENCY(4), .CNT_W(16)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .blk_valid_i(bv[1]), .blk_ready_o(br[1]),
        .blk_data_i(bd[1]), .blk_first_i(bf[1]), .blk_last_i(bl[1]),
        .digest_valid_o(dv[1]), .digest_ready_i(dr[1]), .digest_o(dg[1]),
        .msg_blocks_o(mb1), .busy_o(bz[1]));
    sha1_chain_ctrl #(.COMB_LATENCY(1), .CNT_W(2)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .blk_valid_i(bv[2]), .blk_ready_o(br[2]),
        .blk_data_i(bd[2]), .blk_first_i(bf[2]), .blk_last_i(bl[2]),
        .digest_valid_o(dv[2]), .digest_ready_i(dr[2]), .digest_o(dg[2]),
        .msg_blocks_o(mb2), .busy_o(bz[2]));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference compression straight from the SHA-1 definition (full 80-word schedule)
    function automatic logic [159:0] compress(input logic [159:0] h, input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        {a, b, c, d, e} = h;
        for (int i = 0; i < 80; i++) begin
            case (i / 20)
                0:       begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
                1:       begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
                2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
                default: begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            endcase
            t = rol(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rol(b, 30); b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    function automatic logic [511:0] junk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Present one block, wait for acceptance, then scramble the inputs to prove they are not re-sampled
    task automatic send(input int d, input logic [511:0] data, input logic f, input logic l,
                        input bit hold, output int acc);
        int n = 0;
        @(negedge clk);
        bv[d] = 1'b1; bd[d] = data; bf[d] = f; bl[d] = l;
        while (!br[d] && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin fails++; tests++; $display("FAIL send_timeout dut%0d: ready never rose", d); end
        @(posedge clk); #1;
        acc = cyc;
        bd[d] = junk(); bf[d] = 1'($urandom); bl[d] = 1'($urandom);
        if (!hold) bv[d] = 1'b0;
    endtask

    // Wait for the digest, hold it for 'hold' cycles (valid blocks offered meanwhile), then take it
    task automatic get_dig(input int d, input int hold, output logic [159:0] dig,
                           output int mbv, output int vcyc);
        int n = 0;
        while (!dv[d] && n < 200) begin
            chk("busy_compute", bz[d], 1'b1);
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin fails++; tests++; $display("FAIL digest_timeout dut%0d: digest_valid never rose", d); end
        vcyc = cyc; dig = dg[d]; mbv = int'(mb[d]);
        for (int i = 0; i < hold; i++) begin
            bv[d] = 1'b1; bd[d] = junk(); bf[d] = 1'b1; bl[d] = 1'b1;
            @(posedge clk); #1;
            chk("hold_digest", dg[d], dig);
            chk("hold_mb", mb[d], 160'(mbv));
            chk("hold_ready", br[d], 1'b0);
            chk("hold_valid", dv[d], 1'b1);
            chk("hold_busy", bz[d], 1'b1);
        end
        bv[d] = 1'b0;
        dr[d] = 1'b1;
        @(posedge clk); #1;
        dr[d] = 1'b0;
        chk("valid_drop", dv[d], 1'b0);
        chk("ready_after", br[d], 1'b1);
    endtask

    typedef struct {
        string        nm;
        logic [511:0] b0;
        logic [511:0] b1;
        int           n;
        int           hold;
        logic [159:0] exp;
        int           mbe;
    } vec_t;

    initial begin
        vec_t vt [3];
        logic [511:0] abc_b, empty_b, two0, two1;
        logic [159:0] abc_h, empty_h, two_h, got, chain;
        int acc0, acc1, vc, mbv, cnt, len, seen;

        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [3];
        logic [511:0] abc_b, empty_b, two0, two1, blk;
        logic [159:0] abc_h, empty_h, two_h, got, chain;
        int acc0, acc1, vc, mbv, cnt, len, seen;
        bit f, hold;

        abc_b   = {32'h61626380, 448'h0, 32'h00000018};
        empty_b = {32'h80000000, 480'h0};
        two0    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two1    = {480'h0, 32'h000001c0};
        abc_h   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
        empty_h = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
        two_h   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
        vt[0] = '{"abc",   abc_b,   '0,   1, 0,  abc_h,   1};
        vt[1] = '{"empty", empty_b, '0,   1, 10, empty_h, 1};
        vt[2] = '{"two",   two0,    two1, 2, 2,  two_h,   2};

        for (int d = 0; d < 3; d++) begin
            bv[d] = 0; bf[d] = 0; bl[d] = 0; dr[d] = 0; bd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", br[d], 1'b1);
            chk("rst_valid", dv[d], 1'b0);
            chk("rst_digest", dg[d], IV);
            chk("rst_mb", mb[d], '0);
            chk("rst_busy", bz[d], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Stray digest_ready while nothing is pending
        for (int d = 0; d < 3; d++) dr[d] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("stray_ready_valid", dv[d], 1'b0);
            chk("stray_ready_idle", br[d], 1'b1);
            dr[d] = 1'b0;
        end

        // Known-answer vectors on every instance, with timing checks
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 3; v++) begin
                send(d, vt[v].b0, 1'b1, vt[v].n == 1, vt[v].n > 1, acc0);
                if (vt[v].n == 2) begin
                    send(d, vt[v].b1, 1'b0, 1'b1, 1'b0, acc1);
                    chk({vt[v].nm, "_blk_spacing"}, 160'(acc1 - acc0), 160'(LAT[d] + 1));
                    acc0 = acc1;
                end
                get_dig(d, vt[v].hold, got, mbv, vc);
                chk({vt[v].nm, "_digest"}, got, vt[v].exp);
                chk({vt[v].nm, "_mb"}, 160'(mbv), 160'(vt[v].mbe));
                chk({vt[v].nm, "_latency"}, 160'(vc - acc0), 160'(LAT[d]));
            end
        end

        // Restart mid-message: first block of the two-block message, then "abc" with first
        send(0, two0, 1'b1, 1'b0, 1'b1, acc0);
        send(0, abc_b, 1'b1, 1'b1, 1'b0, acc0);
        get_dig(0, 0, got, mbv, vc);
        chk("restart_digest", got, abc_h);
        chk("restart_mb", 160'(mbv), 160'd1);

        // No blk_first after a handshake still chains from IV
        send(0, abc_b, 1'b0, 1'b1, 1'b0, acc0);
        get_dig(0, 1, got, mbv, vc);
        chk("nofirst_digest", got, abc_h);
        chk("nofirst_mb", 160'(mbv), 160'd1);

        // Counter saturation on the 2-bit instance
        chain = IV;
        for (int j = 0; j < 5; j++) begin
            blk = junk();
            chain = compress(chain, blk);
            send(2, blk, j == 0, j == 4, j < 4, acc0);
        end
        get_dig(2, 0, got, mbv, vc);
        chk("sat_digest", got, chain);
        chk("sat_mb", 160'(mbv), 160'd3);

        // Async reset in the middle of a latency-4 computation
        send(1, two0, 1'b1, 1'b0, 1'b0, acc0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", dv[1], 1'b0);
        chk("abort_ready", br[1], 1'b1);
        chk("abort_busy", bz[1], 1'b0);
        chk("abort_digest", dg[1], IV);
        chk("abort_mb", mb[1], '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (dv[1]) seen = 1;
        end
        chk("abort_no_pulse", 160'(seen), 160'd0);
        send(1, abc_b, 1'b1, 1'b1, 1'b0, acc0);
        get_dig(1, 0, got, mbv, vc);
        chk("after_abort_digest", got, abc_h);
        chk("after_abort_latency", 160'(vc - acc0), 160'd4);

        // Randomized messages against the message-level model
        for (int d = 0; d < 3; d++) begin
            for (int m = 0; m < 8; m++) begin
                chain = IV; cnt = 0;
                len = int'($urandom_range(1, 5));
                for (int j = 0; j < len; j++) begin
                    blk = junk();
                    f = (j == 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
                    if (f) begin chain = IV; cnt = 0; end
                    chain = compress(chain, blk);
                    cnt = (cnt + 1 > SAT[d]) ? SAT[d] : cnt + 1;
                    hold = (j < len - 1) ? bit'($urandom_range(0, 1)) : 1'b0;
                    send(d, blk, f, j == len - 1, hold, acc0);
                end
                get_dig(d, int'($urandom_range(0, 3)), got, mbv, vc);
                chk("rand_digest", got, chain);
                chk("rand_mb", 160'(mbv), 160'(cnt));
                chk("rand_latency", 160'(vc - acc0), 160'(LAT[d]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
